// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between write-back, the CSR file and fetch.
// Accepts an exception, an enabled interrupt or an MRET while idle. It then
// flushes and stalls the pipeline, writes mepc/mcause/mtval/mstatus through the
// single CSR write port, and finally redirects fetch to the handler or to mepc.
// Optional feature: define TRAP_VECTORED_EN to enable vectored interrupt entry
// (mtvec[1:0]==2'b01). Without it, every trap targets the mtvec base.
// Ports:
//   clk_i, rst_i                      clock, async active-low reset
//   exc_req_i/exc_cause_i/exc_pc_i/exc_tval_i   WB exception request
//   mret_req_i                        WB retiring MRET
//   int_meip_i/int_mtip_i/int_msip_i  pending interrupt lines
//   int_pc_i, boundary_i              interrupt return pc, boundary qualifier
//   mie_i/mstatus_i/mtvec_i/mepc_i    current CSR values
//   csr_we_o/csr_waddr_o/csr_wdata_o/csr_ready_i  CSR write port
//   stall_o, flush_o                  pipeline control
//   redirect_valid_o/redirect_pc_o/redirect_ready_i  fetch redirect
//   trap_ack_o                        sequence complete (same cycle as redirect accept)
//   busy_o                            sequencer active
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_req_i,
  input  logic        int_meip_i,
  input  logic        int_mtip_i,
  input  logic        int_msip_i,
  input  logic [31:0] int_pc_i,
  input  logic        boundary_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  input  logic        csr_ready_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        trap_ack_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MTVAL  = 12'h343;
  localparam logic [11:0] A_MSTAT  = 12'h300;
  localparam logic [31:0] C_MEI    = 32'h8000_000B;
  localparam logic [31:0] C_MSI    = 32'h8000_0003;
  localparam logic [31:0] C_MTI    = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTAT, S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {K_EXC, K_INT, K_RET} kind_t;

  state_t           r_state;
  kind_t            r_kind;
  logic [31:0]      r_cause, r_pc, r_tval, r_mstatus, r_mtvec, r_mepc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_flush, r_csr_we, r_redir_valid;
  logic [11:0]      r_csr_waddr;
  logic [31:0]      r_csr_wdata, r_redir_pc;

  logic [31:0] w_mip, w_irq_act, w_int_cause, w_mstat_new, w_base, w_target;
  logic        w_int_take;

  // Interrupt qualification and fixed cause priority MEI > MSI > MTI
  assign w_mip      = (32'(int_meip_i) << 11) | (32'(int_mtip_i) << 7) | (32'(int_msip_i) << 3);
  assign w_irq_act  = mie_i & w_mip;
  assign w_int_take = boundary_i & mstatus_i[3] & (|w_irq_act);

  always_comb begin
    w_int_cause = C_MTI;
    if (w_irq_act[11])     w_int_cause = C_MEI;
    else if (w_irq_act[3]) w_int_cause = C_MSI;
  end

  // New mstatus from the latched copy: trap entry stacks MIE, MRET unstacks it
  always_comb begin
    w_mstat_new        = r_mstatus;
    w_mstat_new[12:11] = 2'b11;
    if (r_kind == K_RET) begin
      w_mstat_new[3] = r_mstatus[7];
      w_mstat_new[7] = 1'b1;
    end else begin
      w_mstat_new[7] = r_mstatus[3];
      w_mstat_new[3] = 1'b0;
    end
  end

  // Redirect target from latched CSRs
  assign w_base = {r_mtvec[31:2], 2'b00};

  always_comb begin
    w_target = w_base;
    if (r_kind == K_RET) begin
      w_target = r_mepc & ~32'd3;
    end
`ifdef TRAP_VECTORED_EN
    else if (r_kind == K_INT && r_mtvec[1:0] == 2'b01) begin
      w_target = w_base + {25'd0, r_cause[4:0], 2'b00};
    end
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = ^r_mtvec[1:0];
`endif

  // Sequencer: state, captured request and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= S_IDLE;
      r_kind        <= K_EXC;
      r_cause       <= '0;
      r_pc          <= '0;
      r_tval        <= '0;
      r_mstatus     <= '0;
      r_mtvec       <= '0;
      r_mepc        <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_flush       <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_waddr   <= '0;
      r_csr_wdata   <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (exc_req_i || w_int_take || mret_req_i) begin
            if (exc_req_i) begin
              r_kind  <= K_EXC;
              r_cause <= exc_cause_i;
              r_pc    <= exc_pc_i;
              r_tval  <= exc_tval_i;
            end else if (w_int_take) begin
              r_kind  <= K_INT;
              r_cause <= w_int_cause;
              r_pc    <= int_pc_i;
              r_tval  <= '0;
            end else begin
              r_kind  <= K_RET;
              r_cause <= '0;
              r_pc    <= '0;
              r_tval  <= '0;
            end
            r_mstatus <= mstatus_i;
            r_mtvec   <= mtvec_i;
            r_mepc    <= mepc_i;
            r_cnt     <= FLUSH_INIT;
            r_busy    <= 1'b1;
            r_flush   <= 1'b1;
            r_state   <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_cnt == '0) begin
            r_flush  <= 1'b0;
            r_csr_we <= 1'b1;
            if (r_kind == K_RET) begin
              r_csr_waddr <= A_MSTAT;
              r_csr_wdata <= w_mstat_new;
              r_state     <= S_W_MSTAT;
            end else begin
              r_csr_waddr <= A_MEPC;
              r_csr_wdata <= {r_pc[31:2], 2'b00};
              r_state     <= S_W_MEPC;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_W_MEPC: if (csr_ready_i) begin
          r_csr_waddr <= A_MCAUSE;
          r_csr_wdata <= r_cause;
          r_state     <= S_W_MCAUSE;
        end
        S_W_MCAUSE: if (csr_ready_i) begin
          r_csr_waddr <= A_MTVAL;
          r_csr_wdata <= r_tval;
          r_state     <= S_W_MTVAL;
        end
        S_W_MTVAL: if (csr_ready_i) begin
          r_csr_waddr <= A_MSTAT;
          r_csr_wdata <= w_mstat_new;
          r_state     <= S_W_MSTAT;
        end
        S_W_MSTAT: if (csr_ready_i) begin
          r_csr_we      <= 1'b0;
          r_csr_waddr   <= '0;
          r_csr_wdata   <= '0;
          r_redir_valid <= 1'b1;
          r_redir_pc    <= w_target;
          r_state       <= S_REDIRECT;
        end
        S_REDIRECT: if (redirect_ready_i) begin
          r_redir_valid <= 1'b0;
          r_redir_pc    <= '0;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = r_busy;
  assign stall_o          = r_busy;
  assign flush_o          = r_flush;
  assign csr_we_o         = r_csr_we;
  assign csr_waddr_o      = r_csr_waddr;
  assign csr_wdata_o      = r_csr_wdata;
  assign redirect_valid_o = r_redir_valid;
  assign redirect_pc_o    = r_redir_pc;
  // Ack must coincide with the accepted redirect, so it follows redirect_ready_i directly
  assign trap_ack_o       = (r_state == S_REDIRECT) & redirect_ready_i;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR writes, redirects
// and per-cycle output probes; a negedge monitor pops and compares them.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        exc_req_i, mret_req_i, int_meip_i, int_mtip_i, int_msip_i, boundary_i;
  logic [31:0] exc_cause_i, exc_pc_i, exc_tval_i, int_pc_i;
  logic [31:0] mie_i, mstatus_i, mtvec_i, mepc_i;
  logic        csr_we_o, csr_ready_i, stall_o, flush_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, redirect_pc_o;
  logic        redirect_valid_o, redirect_ready_i, trap_ack_o, busy_o;

  trap_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_req_i(mret_req_i),
    .int_meip_i(int_meip_i), .int_mtip_i(int_mtip_i), .int_msip_i(int_msip_i),
    .int_pc_i(int_pc_i), .boundary_i(boundary_i),
    .mie_i(mie_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .csr_ready_i(csr_ready_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
    .trap_ack_o(trap_ack_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        redir;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  typedef struct packed {
    int          cyc;
    logic [81:0] want;
    logic [81:0] mask;
  } probe_t;

  localparam logic [81:0] M_ALL  = '1;
  localparam logic [81:0] M_CTL  = {6'h3f, 76'd0};
  localparam logic [81:0] M_ADDR = {6'd0, 12'hfff, 64'd0};
  localparam logic [81:0] M_DATA = {18'd0, 32'hffff_ffff, 32'd0};

  sb_t    sb[$];
  probe_t pq[$];
  string  pn[$];
  sb_t    e;
  probe_t p;
  string  pname;
  int     total = 0;
  int     bad = 0;
  logic   done = 1'b0;
  int     t0;

  function automatic logic [81:0] outs();
    return {busy_o, stall_o, flush_o, csr_we_o, redirect_valid_o, trap_ack_o,
            csr_waddr_o, csr_wdata_o, redirect_pc_o};
  endfunction

  function automatic logic [81:0] mk(input logic [5:0] ctl, input logic [11:0] a, input logic [31:0] d);
    return {ctl, a, d, 32'd0};
  endfunction

  task automatic exp_w(input logic [11:0] a, input logic [31:0] d, input int c);
    sb_t x;
    x.redir = 1'b0; x.addr = a; x.data = d; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic exp_r(input logic [31:0] pc, input int c);
    sb_t x;
    x.redir = 1'b1; x.addr = '0; x.data = pc; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic exp_probe(input string n, input int c, input logic [81:0] w, input logic [81:0] m);
    probe_t x;
    x.cyc = c; x.want = w; x.mask = m;
    pq.push_back(x);
    pn.push_back(n);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge
  always @(negedge clk) begin
    if (csr_we_o && csr_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL csr_write unexpected addr=%h data=%h cyc=%0d", csr_waddr_o, csr_wdata_o, cyc);
      end else begin
        e = sb.pop_front();
        if (e.redir || e.addr != csr_waddr_o || e.data != csr_wdata_o || e.cyc != cyc) begin
          bad++;
          $display("FAIL csr_write got addr=%h data=%h cyc=%0d want redir=%0d addr=%h data=%h cyc=%0d",
                   csr_waddr_o, csr_wdata_o, cyc, e.redir, e.addr, e.data, e.cyc);
        end
      end
    end
    if (redirect_valid_o && redirect_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL redirect unexpected pc=%h cyc=%0d", redirect_pc_o, cyc);
      end else begin
        e = sb.pop_front();
        if (!e.redir || e.data != redirect_pc_o || !trap_ack_o || e.cyc != cyc) begin
          bad++;
          $display("FAIL redirect got pc=%h ack=%0d cyc=%0d want redir=%0d pc=%h ack=1 cyc=%0d",
                   redirect_pc_o, trap_ack_o, cyc, e.redir, e.data, e.cyc);
        end
      end
    end else if (trap_ack_o) begin
      total++;
      bad++;
      $display("FAIL stray_ack got ack=1 want ack=0 cyc=%0d", cyc);
    end
    while (pq.size() != 0 && pq[0].cyc <= cyc) begin
      p = pq.pop_front();
      pname = pn.pop_front();
      total++;
      if (p.cyc != cyc || ((outs() ^ p.want) & p.mask) != '0) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h (probe cyc %0d)",
                 pname, cyc, outs() & p.mask, p.want & p.mask, p.cyc);
      end
    end
    if (done) begin
      total++;
      if (sb.size() != 0 || pq.size() != 0) begin
        bad++;
        $display("FAIL leftover got sb=%0d probes=%0d want 0 0", sb.size(), pq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    rst_i = 1'b0;
    exc_req_i = 1'b0; mret_req_i = 1'b0;
    int_meip_i = 1'b0; int_mtip_i = 1'b0; int_msip_i = 1'b0;
    boundary_i = 1'b1;
    exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0; int_pc_i = '0;
    mie_i = '0; mstatus_i = '0; mtvec_i = '0; mepc_i = '0;
    csr_ready_i = 1'b1; redirect_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    exp_probe("reset_state", cyc, '0, M_ALL);
    wait_to(cyc + 1);
    rst_i = 1'b1;
    wait_to(cyc + 1);

    // Exception entry, direct mode
    exc_cause_i = 32'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
    mstatus_i = 32'h8; mtvec_i = 32'h200; exc_req_i = 1'b1;
    t0 = cyc;
    exp_probe("exc_flush", t0 + 1, mk(6'b111000, '0, '0), M_CTL);
    exp_w(12'h341, 32'h100, t0 + 3);
    exp_probe("exc_w_mepc", t0 + 3, mk(6'b110100, 12'h341, '0), M_CTL | M_ADDR);
    exp_w(12'h342, 32'd2, t0 + 4);
    exp_w(12'h343, 32'hDEAD, t0 + 5);
    exp_w(12'h300, 32'h1880, t0 + 6);
    exp_r(32'h200, t0 + 7);
    exp_probe("exc_idle_after", t0 + 8, '0, M_CTL);
    wait_to(t0 + 8);
    exc_req_i = 1'b0;
    wait_to(cyc + 1);

    // MRET
    mstatus_i = 32'h1880; mepc_i = 32'h344; mret_req_i = 1'b1;
    t0 = cyc;
    exp_w(12'h300, 32'h1888, t0 + 3);
    exp_r(32'h344, t0 + 4);
    wait_to(t0 + 5);
    mret_req_i = 1'b0;
    wait_to(cyc + 1);

    // Interrupt held off by boundary_i, then MEI over MTI with vectored mtvec
    mie_i = 32'h880; mstatus_i = 32'h8; mtvec_i = 32'h201; int_pc_i = 32'h404;
    boundary_i = 1'b0; int_meip_i = 1'b1; int_mtip_i = 1'b1;
    t0 = cyc;
    exp_probe("no_boundary_1", t0 + 1, '0, M_CTL);
    exp_probe("no_boundary_2", t0 + 2, '0, M_CTL);
    wait_to(t0 + 2);
    boundary_i = 1'b1;
    t0 = cyc;
    exp_w(12'h341, 32'h404, t0 + 3);
    exp_w(12'h342, 32'h8000_000B, t0 + 4);
    exp_w(12'h343, 32'h0, t0 + 5);
    exp_w(12'h300, 32'h1880, t0 + 6);
`ifdef TRAP_VECTORED_EN
    exp_r(32'h22C, t0 + 7);
`else
    exp_r(32'h200, t0 + 7);
`endif
    wait_to(t0 + 1);
    int_meip_i = 1'b0; int_mtip_i = 1'b0;
    wait_to(t0 + 8);

    // MSI over MTI, direct mtvec
    mie_i = 32'h088; mtvec_i = 32'h200; int_pc_i = 32'h502;
    int_msip_i = 1'b1; int_mtip_i = 1'b1;
    t0 = cyc;
    exp_w(12'h341, 32'h500, t0 + 3);
    exp_w(12'h342, 32'h8000_0003, t0 + 4);
    exp_w(12'h343, 32'h0, t0 + 5);
    exp_w(12'h300, 32'h1880, t0 + 6);
    exp_r(32'h200, t0 + 7);
    wait_to(t0 + 1);
    int_msip_i = 1'b0; int_mtip_i = 1'b0;
    wait_to(t0 + 8);
    mie_i = '0;

    // CSR back-pressure: mepc write held for 3 extra cycles
    exc_cause_i = 32'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
    mstatus_i = 32'h8; mtvec_i = 32'h200; exc_req_i = 1'b1; csr_ready_i = 1'b0;
    t0 = cyc;
    for (int k = 3; k <= 6; k++)
      exp_probe("mepc_hold", t0 + k, mk(6'b110100, 12'h341, 32'h100), M_CTL | M_ADDR | M_DATA);
    exp_w(12'h341, 32'h100, t0 + 6);
    exp_w(12'h342, 32'd2, t0 + 7);
    exp_w(12'h343, 32'hDEAD, t0 + 8);
    exp_w(12'h300, 32'h1880, t0 + 9);
    exp_r(32'h200, t0 + 10);
    wait_to(t0 + 6);
    csr_ready_i = 1'b1;
    wait_to(t0 + 11);
    exc_req_i = 1'b0;
    wait_to(cyc + 1);

    // Reset while in W_MCAUSE
    exc_req_i = 1'b1;
    t0 = cyc;
    exp_w(12'h341, 32'h100, t0 + 3);
    exp_probe("in_w_mcause", t0 + 4, mk(6'b110100, 12'h342, '0), M_CTL | M_ADDR);
    wait_to(t0 + 4);
    csr_ready_i = 1'b0;
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    exc_req_i = 1'b0;
    csr_ready_i = 1'b1;
    exp_probe("reset_abort_1", t0 + 5, '0, M_ALL);
    exp_probe("reset_abort_2", t0 + 6, '0, M_ALL);
    for (int k = 7; k <= 9; k++) exp_probe("after_abort", t0 + k, '0, M_ALL);
    wait_to(t0 + 7);
    rst_i = 1'b1;
    wait_to(t0 + 10);

    // Exception + MRET together, interrupt pending but globally disabled
    exc_cause_i = 32'd5; exc_pc_i = 32'h123; exc_tval_i = 32'h55;
    mstatus_i = 32'h0; mtvec_i = 32'h301; mepc_i = 32'h999;
    mie_i = 32'h800; int_meip_i = 1'b1; boundary_i = 1'b1;
    exc_req_i = 1'b1; mret_req_i = 1'b1;
    t0 = cyc;
    exp_w(12'h341, 32'h120, t0 + 3);
    exp_w(12'h342, 32'd5, t0 + 4);
    exp_w(12'h343, 32'h55, t0 + 5);
    exp_w(12'h300, 32'h1800, t0 + 6);
    exp_r(32'h300, t0 + 7);
    for (int k = 9; k <= 13; k++) exp_probe("int_masked_idle", t0 + k, '0, M_CTL);
    wait_to(t0 + 8);
    exc_req_i = 1'b0; mret_req_i = 1'b0;
    wait_to(t0 + 14);

    done = 1'b1;
  end

endmodule
